// File: rtl/strip_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port between NUM_STRIPS strip drivers.
// Translates each strip's local offset into its region and returns the byte after READ_LATENCY+1 cycles.
module strip_read_arbiter #(
  parameter int NUM_STRIPS    = 4,
  parameter int ADDRESS_WIDTH = 13,
  parameter int OFFSET_WIDTH  = 9,
  parameter int STRIP_STRIDE  = 480,
  parameter int READ_LATENCY  = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_STRIPS-1:0]              req,
  input  logic [NUM_STRIPS*OFFSET_WIDTH-1:0] offset,
  output logic [NUM_STRIPS-1:0]              gnt,
  output logic [NUM_STRIPS-1:0]              rvalid,
  output logic [7:0]                         rdata,
  output logic                               addr_err,
  output logic [ADDRESS_WIDTH-1:0]           mem_addr,
  input  logic [7:0]                         mem_dout
);

  localparam int PTR_W = $clog2(NUM_STRIPS);

  logic [PTR_W-1:0]         ptr;
  logic [NUM_STRIPS-1:0]    eligible;
  logic                     win_valid;
  logic [PTR_W-1:0]         win_idx;
  logic [OFFSET_WIDTH-1:0]  win_off;
  logic [31:0]              win_full;
  logic                     win_err;
  logic [NUM_STRIPS-1:0]    tap [READ_LATENCY];

  // A strip whose gnt is high this cycle is masked so a held req is not granted twice.
  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    eligible  = req & ~gnt;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_STRIPS; k++) begin
      logic [31:0] idx;
      idx = (32'(ptr) + 32'(k)) % 32'(NUM_STRIPS);
      if (!win_valid && eligible[idx[PTR_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = idx[PTR_W-1:0];
      end
    end
    win_off  = offset[win_idx*OFFSET_WIDTH +: OFFSET_WIDTH];
    win_full = 32'(win_idx) * 32'(STRIP_STRIDE) + 32'(win_off);
    win_err  = 32'(win_off) >= 32'(STRIP_STRIDE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      ptr      <= PTR_W'(NUM_STRIPS - 1);
      mem_addr <= '0;
      addr_err <= 1'b0;
    end else begin
      gnt <= win_valid ? (NUM_STRIPS'(1) << win_idx) : '0;
      if (win_valid) begin
        ptr      <= win_idx;
        mem_addr <= win_full[ADDRESS_WIDTH-1:0];
        addr_err <= addr_err | win_err;
      end
    end
  end

  // One-hot return pipeline: tap[READ_LATENCY-1] lines up with valid mem_dout.
  // NOTE: this tiny pipeline array is reset so reads in flight at reset never produce rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < READ_LATENCY; k++) tap[k] <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      tap[0] <= gnt;
      for (int k = 1; k < READ_LATENCY; k++) tap[k] <= tap[k-1];
      rvalid <= tap[READ_LATENCY-1];
      if (|tap[READ_LATENCY-1]) rdata <= mem_dout;
    end
  end

endmodule

// File: tb/tb_strip_read_arbiter.sv
// Bench for strip_read_arbiter: directed literal checks plus randomized handshakes
// compared every cycle against a queue-based round-robin model.
module tb_strip_read_arbiter;

  localparam int N      = 4;
  localparam int AW     = 13;
  localparam int OW     = 9;
  localparam int STRIDE = 480;
  localparam int RL     = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0, req2 = '0;
  logic [N*OW-1:0] offset = '0, offset2 = '0;
  logic [N-1:0]  gnt, rvalid, gnt2, rvalid2;
  logic [7:0]    rdata, rdata2, mem_dout, mem_dout2, bram2_mid;
  logic          addr_err, addr_err2;
  logic [AW-1:0] mem_addr, mem_addr2;

  logic [7:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  strip_read_arbiter #(.NUM_STRIPS(N), .ADDRESS_WIDTH(AW), .OFFSET_WIDTH(OW),
                       .STRIP_STRIDE(STRIDE), .READ_LATENCY(RL)) u_dut (
    .clk(clk), .rst(rst), .req(req), .offset(offset), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .addr_err(addr_err), .mem_addr(mem_addr), .mem_dout(mem_dout));

  strip_read_arbiter #(.NUM_STRIPS(N), .ADDRESS_WIDTH(AW), .OFFSET_WIDTH(OW),
                       .STRIP_STRIDE(STRIDE), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .offset(offset2), .gnt(gnt2), .rvalid(rvalid2),
    .rdata(rdata2), .addr_err(addr_err2), .mem_addr(mem_addr2), .mem_dout(mem_dout2));

  // BRAM models: one-cycle and two-cycle read latency.
  always @(posedge clk) mem_dout <= mem[mem_addr];
  always @(posedge clk) begin
    bram2_mid <= mem[mem_addr2];
    mem_dout2 <= bram2_mid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: round-robin over req minus last cycle's grant, reads queued by due cycle.
  typedef struct { int strip; int due; logic [7:0] data; } rd_t;
  rd_t          pend[$];
  int           cyc = 0;
  int           m_last;
  logic [N-1:0] m_gnt, m_rvalid;
  logic [7:0]   m_rdata;
  logic         m_err;
  logic [AW-1:0] m_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last = N - 1; m_gnt = '0; m_rvalid = '0; m_rdata = '0; m_err = 1'b0; m_addr = '0;
      pend.delete();
    end else begin
      int win;
      cyc++;
      win = -1;
      for (int k = 1; k <= N; k++) begin
        int s;
        s = (m_last + k) % N;
        if (win < 0 && req[s] && !m_gnt[s]) win = s;
      end
      m_gnt = '0;
      if (win >= 0) begin
        int off, a;
        off = int'(offset[win*OW +: OW]);
        a = (win * STRIDE + off) % (1 << AW);
        m_gnt[win] = 1'b1;
        m_addr = AW'(a);
        if (off >= STRIDE) m_err = 1'b1;
        pend.push_back('{strip: win, due: cyc + RL + 1, data: mem[a]});
        m_last = win;
      end
      m_rvalid = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_rvalid[pend[0].strip] = 1'b1;
        m_rdata = pend[0].data;
        void'(pend.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      check("model_gnt", gnt, m_gnt);
      check("model_rvalid", rvalid, m_rvalid);
      check("model_rdata", rdata, m_rdata);
      check("model_mem_addr", mem_addr, m_addr);
      check("model_addr_err", addr_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; req2 = '0; offset = '0; offset2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic new_offset(input int i);
    if ($urandom_range(63, 0) == 0) offset[i*OW +: OW] = OW'($urandom_range(511, 480));
    else                            offset[i*OW +: OW] = OW'($urandom_range(479, 0));
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    cmp_en = 1'b1;

    // Single request on strip 0.
    do_reset();
    check("reset_gnt", gnt, 0);
    check("reset_mem_addr", mem_addr, 0);
    req = 4'b0001; offset[0 +: OW] = 9'd5;
    tick();
    check("t1_gnt", gnt, 4'b0001);
    check("t1_mem_addr", mem_addr, 5);
    @(negedge clk) req = '0;
    tick();
    check("t1_rvalid_early", rvalid, 0);
    tick();
    check("t1_rvalid", rvalid, 4'b0001);
    check("t1_rdata", rdata, mem[5]);

    // All four strips requesting continuously.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_gnt", gnt, 32'(1) << (k % 4));
      check("t2_mem_addr", mem_addr, (k % 4) * 480);
    end
    @(negedge clk) req = '0;

    // Strip 2 alone holding req: grants only on alternate cycles.
    do_reset();
    req = 4'b0100; offset[2*OW +: OW] = 9'd3;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t3_gnt", gnt, (k % 2 == 0) ? 4'b0100 : 4'b0000);
      check("t3_rvalid", rvalid, (k >= 2 && k % 2 == 0) ? 4'b0100 : 4'b0000);
    end
    @(negedge clk) req = '0;

    // Out-of-range offset sets sticky addr_err.
    do_reset();
    req = 4'b0010; offset[1*OW +: OW] = 9'd480;
    tick();
    check("t4_mem_addr", mem_addr, 960);
    check("t4_addr_err", addr_err, 1);
    @(negedge clk) req = '0;
    repeat (4) tick();
    check("t4_addr_err_sticky", addr_err, 1);
    do_reset();
    check("t4_addr_err_cleared", addr_err, 0);

    // Reset one cycle after a grant drops the read in flight.
    req = 4'b0001; offset[0 +: OW] = 9'd9;
    tick();
    check("t5_gnt", gnt, 4'b0001);
    @(negedge clk) req = '0;
    tick();
    @(negedge clk) rst = 1'b1;
    tick();
    check("t5_rvalid_dropped", rvalid, 0);
    @(negedge clk) req = 4'b1111; offset = '0; rst = 1'b0;
    tick();
    check("t5_first_gnt", gnt, 4'b0001);
    check("t5_no_stale_rvalid", rvalid, 0);
    @(negedge clk) req = '0;

    // READ_LATENCY=2 instance, strip 3 offset 7.
    do_reset();
    req2 = 4'b1000; offset2[3*OW +: OW] = 9'd7;
    tick();
    check("t6_gnt", gnt2, 4'b1000);
    check("t6_mem_addr", mem_addr2, 1447);
    @(negedge clk) req2 = '0;
    tick();
    check("t6_rvalid_g1", rvalid2, 0);
    tick();
    check("t6_rvalid_g2", rvalid2, 0);
    tick();
    check("t6_rvalid", rvalid2, 4'b1000);
    check("t6_rdata", rdata2, mem[1447]);

    // Randomized handshakes against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (m_gnt[i]) begin
            if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
            else new_offset(i);
          end
        end else if ($urandom_range(3, 0) == 0) begin
          req[i] = 1'b1;
          new_offset(i);
        end
      end
      @(negedge clk);
    end
    req = '0;
    repeat (5) @(negedge clk);
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
